// File: rtl/vga_scan_reader.sv
// vga_scan_reader
// Display-side reader for the video framebuffer. Generates VGA raster timing,
// reads the image window back from video RAM in raster order through the RAM's
// synchronous read port, and drives RGB332 and sync pins. Pixels outside the
// image window show BORDER; pixels outside the visible area are blanked.
//
// Ports
//   Clock        in   system clock, rising edge
//   Reset        in   asynchronous, active-low reset
//   oRAMAddress  out  framebuffer read address {row[7:0], col[7:0]}
//   oRAMRead     out  read enable, high while the stage-1 pixel is in the image
//   iRAMData     in   RGB332 pixel, valid one Clock after oRAMAddress
//   oVGA_R/G/B   out  colour pins (3/3/2 bits)
//   oHSync       out  horizontal sync, active-low
//   oVSync       out  vertical sync, active-low
//   oFrameStart  out  one-Clock pulse when pixel (0,0) reaches the pins
module vga_scan_reader #(
  parameter int         CLK_DIV   = 2,
  parameter int         H_VISIBLE = 640,
  parameter int         H_FRONT   = 16,
  parameter int         H_SYNC    = 96,
  parameter int         H_BACK    = 48,
  parameter int         V_VISIBLE = 480,
  parameter int         V_FRONT   = 10,
  parameter int         V_SYNC    = 2,
  parameter int         V_BACK    = 33,
  parameter int         IMG_W     = 256,
  parameter int         IMG_H     = 256,
  parameter logic [7:0] BORDER    = 8'h00
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oRAMAddress,
  output logic        oRAMRead,
  input  logic [7:0]  iRAMData,
  output logic [2:0]  oVGA_R,
  output logic [2:0]  oVGA_G,
  output logic [1:0]  oVGA_B,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oFrameStart
);

  localparam int              DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] IMG_W10  = 10'(IMG_W);
  localparam logic [9:0] IMG_H10  = 10'(IMG_H);

  logic [DIV_W-1:0] r_div;
  logic [9:0]       r_h;
  logic [9:0]       r_v;
  logic             w_tick;

  // stage 1
  logic [15:0] r_addr;
  logic        r_read;
  logic        r_s1_vis;
  logic        r_s1_hact;
  logic        r_s1_vact;
  logic        r_s1_first;

  // stage 2
  logic [7:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  logic w_in_img;
  logic w_vis;
  logic w_hact;
  logic w_vact;
  logic w_first;

  assign w_tick   = (r_div == DIV_LAST);
  assign w_in_img = (r_h < IMG_W10) && (r_v < IMG_H10);
  assign w_vis    = (r_h < H_VIS) && (r_v < V_VIS);
  assign w_hact   = (r_h >= HS_FIRST) && (r_h <= HS_LAST);
  assign w_vact   = (r_v >= VS_FIRST) && (r_v <= VS_LAST);
  assign w_first  = (r_h == 10'd0) && (r_v == 10'd0);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 1'b1;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_tick) begin
      if (r_h == H_LAST) begin
        r_h <= '0;
        r_v <= (r_v == V_LAST) ? 10'd0 : r_v + 10'd1;
      end else begin
        r_h <= r_h + 10'd1;
      end
    end
  end

  // Sync flags are held active-high internally so that cleared stage-1
  // registers feed inactive (high) levels to the pins on the first tick.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_s1_vis   <= 1'b0;
      r_s1_hact  <= 1'b0;
      r_s1_vact  <= 1'b0;
      r_s1_first <= 1'b0;
    end else if (w_tick) begin
      // Address holds outside the window; oRAMRead=0 marks it don't-care.
      if (w_in_img) begin
        r_addr <= {r_v[7:0], r_h[7:0]};
      end
      r_read     <= w_in_img;
      r_s1_vis   <= w_vis;
      r_s1_hact  <= w_hact;
      r_s1_vact  <= w_vact;
      r_s1_first <= w_first;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (w_tick) begin
        // RAM data is only trusted when this pixel issued a read.
        if (r_read) begin
          r_rgb <= iRAMData;
        end else if (r_s1_vis) begin
          r_rgb <= BORDER;
        end else begin
          r_rgb <= 8'h00;
        end
        r_hsync       <= !r_s1_hact;
        r_vsync       <= !r_s1_vact;
        r_frame_start <= r_s1_first;
      end
    end
  end

  assign oRAMAddress = r_addr;
  assign oRAMRead    = r_read;
  assign oVGA_R      = r_rgb[7:5];
  assign oVGA_G      = r_rgb[4:2];
  assign oVGA_B      = r_rgb[1:0];
  assign oHSync      = r_hsync;
  assign oVSync      = r_vsync;
  assign oFrameStart = r_frame_start;

endmodule

// File: tb/tb_vga_scan_reader.sv
// tb_vga_scan_reader
// Bench for vga_scan_reader: full horizontal timing, shortened vertical timing
// (15 lines/frame) and a 256x6 image window so several frames fit in a short
// run. A RAM model returns row^col. A time-based raster model predicts every
// output on every Clock; directed checks pin literal values.
module tb_vga_scan_reader;

  localparam int CD  = 2;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48;
  localparam int VV = 8,   VF = 2,  VS = 2,  VB = 3;
  localparam int IW = 256, IH = 6;
  localparam logic [7:0] BRD = 8'hE0;
  localparam int HT = HV + HF + HS + HB;  // 800
  localparam int VT = VV + VF + VS + VB;  // 15
  localparam int FRAME = HT * VT;         // pixels per frame

  logic        Clock = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] oRAMAddress;
  logic        oRAMRead;
  logic [7:0]  iRAMData = 8'h00;
  logic [2:0]  oVGA_R;
  logic [2:0]  oVGA_G;
  logic [1:0]  oVGA_B;
  logic        oHSync;
  logic        oVSync;
  logic        oFrameStart;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int k     = 0;   // rising edges since Reset released
  int fs_q[$];

  vga_scan_reader #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .IMG_W(IW), .IMG_H(IH), .BORDER(BRD)
  ) dut (
    .Clock(Clock), .Reset(rst_n), .oRAMAddress(oRAMAddress), .oRAMRead(oRAMRead),
    .iRAMData(iRAMData), .oVGA_R(oVGA_R), .oVGA_G(oVGA_G), .oVGA_B(oVGA_B),
    .oHSync(oHSync), .oVSync(oVSync), .oFrameStart(oFrameStart)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    iRAMData <= oRAMAddress[15:8] ^ oRAMAddress[7:0];
    cyc <= cyc + 1;
  end

  always @(posedge Clock or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  always @(negedge Clock) begin
    if (oFrameStart) fs_q.push_back(cyc);
  end

  function automatic logic [7:0] pix_colour(input int h, input int v);
    if (h < IW && v < IH) return 8'(v) ^ 8'(h);
    if (h < HV && v < VV) return BRD;
    return 8'h00;
  endfunction

  // Raster model: after tick m the pins show pixel m-2 and stage 1 holds m-1.
  always @(negedge Clock) begin
    int m, p, h, v;
    logic [7:0]  e_rgb, a_rgb;
    logic        e_hs, e_vs, e_fs, e_rd;
    logic [15:0] e_addr, a_addr;
    logic        addr_care;
    m = k / CD;
    e_rgb = 8'h00; e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0;
    e_rd = 1'b0; e_addr = 16'h0000; addr_care = 1'b1;
    if (m >= 2) begin
      p = m - 2; h = p % HT; v = (p / HT) % VT;
      e_rgb = pix_colour(h, v);
      e_hs  = !(h >= HV + HF && h < HV + HF + HS);
      e_vs  = !(v >= VV + VF && v < VV + VF + VS);
      e_fs  = (k % CD == 0) && (p % FRAME == 0);
    end
    if (m >= 1) begin
      p = m - 1; h = p % HT; v = (p / HT) % VT;
      e_rd = (h < IW) && (v < IH);
      e_addr = {8'(v), 8'(h)};
      addr_care = e_rd;
    end
    a_rgb  = {oVGA_R, oVGA_G, oVGA_B};
    a_addr = addr_care ? oRAMAddress : 16'h0000;
    if (!addr_care) e_addr = 16'h0000;
    total++;
    if (a_rgb !== e_rgb || oHSync !== e_hs || oVSync !== e_vs || oFrameStart !== e_fs ||
        oRAMRead !== e_rd || a_addr !== e_addr) begin
      bad++;
      $display("FAIL scan k=%0d got rgb=%h hs=%b vs=%b fs=%b rd=%b addr=%h expected rgb=%h hs=%b vs=%b fs=%b rd=%b addr=%h",
               k, a_rgb, oHSync, oVSync, oFrameStart, oRAMRead, a_addr,
               e_rgb, e_hs, e_vs, e_fs, e_rd, e_addr);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_k(input string name, input int target);
    for (int i = 0; i < 70000 && k != target; i++) @(negedge Clock);
    chk({"reach_", name}, k, target);
  endtask

  task automatic wait_sig(input bit use_vs, input logic val, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge Clock);
      if ((use_vs ? oVSync : oHSync) == val) begin
        t = cyc;
        break;
      end
    end
  endtask

  initial begin
    int c0, c1, n0, t1, t2, t3;
    repeat (3) @(negedge Clock);
    chk("rst_hs", oHSync, 1);
    chk("rst_vs", oVSync, 1);
    chk("rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 0);
    chk("rst_read", oRAMRead, 0);
    chk("rst_fs", oFrameStart, 0);
    @(posedge Clock); @(posedge Clock);
    #2 rst_n = 1'b1;
    c0 = cyc;

    wait_k("tick1", 2);
    chk("addr_first", oRAMAddress, 16'h0000);
    chk("read_first", oRAMRead, 1);
    wait_k("fs", 4);
    chk("fs_pulse", oFrameStart, 1);

    wait_sig(1'b0, 1'b0, 2000, t1);
    wait_sig(1'b0, 1'b1, 2000, t2);
    wait_sig(1'b0, 1'b0, 2000, t3);
    chk("hs_low_width", t2 - t1, 192);
    chk("hs_period", t3 - t1, 1600);

    // pixel (5,3): stage 1 at k=2*(p+1), pins at k=2*(p+2), p=3*800+5
    wait_k("s1_5_3", 4812);
    chk("addr_0305", oRAMAddress, 16'h0305);
    chk("read_5_3", oRAMRead, 1);
    wait_k("pin_5_3", 4814);
    chk("rgb_5_3", {oVGA_R, oVGA_G, oVGA_B}, 8'h06);
    chk("g_5_3", oVGA_G, 1);
    chk("b_5_3", oVGA_B, 2);
    wait_k("s1_300_3", 5402);
    chk("read_300_3", oRAMRead, 0);
    wait_k("pin_300_3", 5404);
    chk("r_300_3", oVGA_R, 7);
    chk("rgb_300_3", {oVGA_R, oVGA_G, oVGA_B}, 8'hE0);
    wait_k("pin_700_3", 6204);
    chk("rgb_700_3", {oVGA_R, oVGA_G, oVGA_B}, 8'h00);
    wait_k("pin_255_5", 8514);
    chk("rgb_255_5", {oVGA_R, oVGA_G, oVGA_B}, 8'hFA);
    wait_k("pin_256_5", 8516);
    chk("rgb_256_5", {oVGA_R, oVGA_G, oVGA_B}, 8'hE0);
    wait_k("pin_5_6", 9614);
    chk("rgb_5_6", {oVGA_R, oVGA_G, oVGA_B}, 8'hE0);
    wait_k("pin_5_9", 14414);
    chk("rgb_5_9", {oVGA_R, oVGA_G, oVGA_B}, 8'h00);

    wait_sig(1'b1, 1'b0, 5000, t1);
    wait_sig(1'b1, 1'b1, 5000, t2);
    wait_sig(1'b1, 1'b0, 25000, t3);
    chk("vs_low_width", t2 - t1, 3200);
    chk("vs_period", t3 - t1, 24000);
    chk("vs_fall_k", t1 - c0, 16004);
    chk("fs_count", fs_q.size(), 2);
    chk("fs_first", fs_q.size() >= 1 ? fs_q[0] - c0 : -1, 4);
    chk("fs_period", fs_q.size() >= 2 ? fs_q[1] - fs_q[0] : -1, 24000);

    // pins at pixel (400,5) of the third frame
    wait_k("mid", 56804);
    chk("pre_rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 8'hE0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_hs", oHSync, 1);
    chk("mid_rst_vs", oVSync, 1);
    chk("mid_rst_rgb", {oVGA_R, oVGA_G, oVGA_B}, 0);
    chk("mid_rst_read", oRAMRead, 0);
    chk("mid_rst_addr", oRAMAddress, 0);
    repeat (3) @(posedge Clock);
    #2 rst_n = 1'b1;
    c1 = cyc;
    n0 = fs_q.size();
    repeat (200) @(negedge Clock);
    chk("fs_after_count", fs_q.size() - n0, 1);
    chk("fs_after_rst", fs_q.size() > n0 ? fs_q[$] - c1 : -1, 4);
    repeat (3000) @(negedge Clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
